// File: rtl/ps2_pkg.sv
// Shared types and helpers for the device-side PS/2 transmitter.
// Holds the FSM state encoding, frame geometry, parity helper and synchroniser depth.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUS,
    ST_BIT_HI,
    ST_BIT_LO,
    ST_GAP
  } state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int SYNC_STAGES    = 2;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Small synchronous FIFO; the head word is visible on rdata without popping.
// DEPTH must be a power of two so the pointers wrap naturally.
module ps2_byte_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; only words below level are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: queues bytes and clocks out 11-bit odd-parity frames,
// generating PS/2 clock itself and backing off (then resending) whenever the host inhibits.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF    = 2000,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDLE_CYCLES = 2500,
  parameter int GAP_CYCLES  = 2500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          tx_abort,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  inout  wire                           ps2clk,
  inout  wire                           ps2data
);

  localparam int CNT_MAX0 = (IDLE_CYCLES > GAP_CYCLES) ? IDLE_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > CLK_HALF) ? CNT_MAX0 : CLK_HALF;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  // Released clock takes SYNC_STAGES cycles to read high again; short half-periods
  // shrink the inhibit blanking window to that latency so inhibit stays detectable.
  localparam int GUARD    = (CLK_HALF > 4) ? 4 : SYNC_STAGES;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_HALF - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
  localparam logic [3:0]       LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  state_t                     state, state_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic [3:0]                 bit_idx, bit_idx_n;
  logic [PS2_FRAME_BITS-1:0]  frame;
  logic                       load, pop, done_n, abort_n;
  logic [SYNC_STAGES-1:0]     clk_sync, data_sync;
  logic                       clk_s, data_s;
  logic [7:0]                 head;
  logic                       full, empty;
  logic                       clk_low, data_low;

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .pop   (pop),
    .wdata (tx_data),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign tx_ready = !full;
  assign busy     = (state == ST_BIT_HI) || (state == ST_BIT_LO) || (state == ST_GAP);
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];

  // Drives depend only on the state register so reset releases both lines at once.
  assign clk_low  = (state == ST_BIT_LO);
  assign data_low = ((state == ST_BIT_HI) || (state == ST_BIT_LO)) && !frame[bit_idx];
  assign ps2clk   = clk_low  ? 1'b0 : 1'bz;
  assign ps2data  = data_low ? 1'b0 : 1'bz;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    load      = 1'b0;
    pop       = 1'b0;
    done_n    = 1'b0;
    abort_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!empty) state_n = ST_WAIT_BUS;
      end
      ST_WAIT_BUS: begin
        if (clk_s && data_s) begin
          if (cnt == IDLE_LAST) begin
            state_n   = ST_BIT_HI;
            cnt_n     = '0;
            bit_idx_n = '0;
            load      = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          cnt_n = '0;
        end
      end
      ST_BIT_HI: begin
        if ((cnt >= GUARD_CNT) && !clk_s) begin
          state_n = ST_WAIT_BUS;
          cnt_n   = '0;
          abort_n = 1'b1;
        end else if (cnt == HALF_LAST) begin
          state_n = ST_BIT_LO;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_BIT_LO: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (bit_idx == LAST_BIT) begin
            state_n = ST_GAP;
            pop     = 1'b1;
            done_n  = 1'b1;
          end else begin
            state_n   = ST_BIT_HI;
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Synchronisers reset to the released (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      tx_done   <= 1'b0;
      tx_abort  <= 1'b0;
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      tx_done   <= done_n;
      tx_abort  <= abort_n;
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2data};
    end
  end

  always_ff @(posedge clk) begin
    if (load) frame <= {1'b1, odd_parity(head), head, 1'b0};
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: a pulled-up host model samples data on clock falls.
// Table-driven single frames plus hand-written sequences for queueing, inhibit and reset.
module tb_ps2_device_tx;

  localparam int CLK_HALF    = 4;
  localparam int FIFO_DEPTH  = 4;
  localparam int IDLE_CYCLES = 8;
  localparam int GAP_CYCLES  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_abort;
  logic [2:0] fifo_level;
  wire        ps2clk_w;
  wire        ps2data_w;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;

  pullup (ps2clk_w);
  pullup (ps2data_w);
  assign ps2clk_w  = host_clk_low  ? 1'b0 : 1'bz;
  assign ps2data_w = host_data_low ? 1'b0 : 1'bz;

  ps2_device_tx #(
    .CLK_HALF    (CLK_HALF),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .IDLE_CYCLES (IDLE_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_abort   (tx_abort),
    .fifo_level (fifo_level),
    .ps2clk     (ps2clk_w),
    .ps2data    (ps2data_w)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   abort_cnt = 0;
  int   cyc = 0;
  logic busy_q = 1'b0;
  logic bits_q[$];
  int   done_cyc[$];
  int   start_cyc[$];

  // Host samples data on every device-generated clock fall.
  always @(negedge ps2clk_w) begin
    if (!host_clk_low && !rst) bits_q.push_back(ps2data_w);
  end

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= busy;
    if (tx_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc.push_back(cyc);
    end
    if (tx_abort) abort_cnt <= abort_cnt + 1;
    if (busy && !busy_q) start_cyc.push_back(cyc);
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk); #1;
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_bits(input int n, input int budget, input string name);
    int k = 0;
    while (bits_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, bits_q.size(), n);
  endtask

  task automatic take_frame(output logic [10:0] f);
    f = '0;
    for (int i = 0; i < 11; i++) begin
      if (bits_q.size() > 0) f[i] = bits_q.pop_front();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [10:0] got;
  int          d0, a0, gap;
  logic        rdy [5];

  initial begin
    vecs[0] = '{8'hA5, 1'b1};
    vecs[1] = '{8'h00, 1'b1};
    vecs[2] = '{8'hFF, 1'b1};
    vecs[3] = '{8'h3C, 1'b1};
    vecs[4] = '{8'h01, 1'b0};
    vecs[5] = '{8'h80, 1'b0};
    vecs[6] = '{8'h7F, 1'b0};
    vecs[7] = '{8'h12, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset tx_ready", tx_ready, 1);
    check("reset busy", busy, 0);
    check("reset tx_done", tx_done, 0);
    check("reset tx_abort", tx_abort, 0);
    check("reset fifo_level", fifo_level, 0);
    check("reset ps2clk", ps2clk_w, 1);
    check("reset ps2data", ps2data_w, 1);

    // Single frames, one byte at a time.
    for (int v = 0; v < 8; v++) begin
      bits_q.delete();
      d0 = done_cnt;
      push_byte(vecs[v].data);
      @(negedge clk);
      check($sformatf("vec%0d level after push", v), fifo_level, 1);
      wait_bits(11, 300, $sformatf("vec%0d bit count", v));
      take_frame(got);
      check($sformatf("vec%0d frame", v), got, {1'b1, vecs[v].par, vecs[v].data, 1'b0});
      idle(CLK_HALF + 3);
      check($sformatf("vec%0d tx_done pulses", v), done_cnt - d0, 1);
      check($sformatf("vec%0d level after frame", v), fifo_level, 0);
      idle(GAP_CYCLES + 4);
    end

    // Back-to-back queue of three bytes with inter-frame gaps.
    bits_q.delete();
    done_cyc.delete();
    start_cyc.delete();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    wait_bits(33, 800, "b2b bit count");
    take_frame(got);
    check("b2b frame0", got, {1'b1, 1'b1, 8'h00, 1'b0});
    take_frame(got);
    check("b2b frame1", got, {1'b1, 1'b1, 8'hFF, 1'b0});
    take_frame(got);
    check("b2b frame2", got, {1'b1, 1'b1, 8'h3C, 1'b0});
    idle(CLK_HALF + 3);
    check("b2b done count", done_cyc.size(), 3);
    check("b2b start count", start_cyc.size(), 3);
    gap = (start_cyc.size() > 1 && done_cyc.size() > 0) ? start_cyc[1] - done_cyc[0] : 0;
    check("b2b gap0 >= 8", gap >= GAP_CYCLES, 1);
    gap = (start_cyc.size() > 2 && done_cyc.size() > 1) ? start_cyc[2] - done_cyc[1] : 0;
    check("b2b gap1 >= 8", gap >= GAP_CYCLES, 1);
    idle(GAP_CYCLES + 4);

    // Five pushes in consecutive cycles: the fifth finds the queue full.
    bits_q.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      tx_data  = 8'(i + 1);
      tx_valid = 1'b1;
      @(posedge clk); #1;
      rdy[i] = tx_ready;
    end
    tx_valid = 1'b0;
    check("full ready after 3rd", rdy[2], 1);
    check("full ready after 4th", rdy[3], 0);
    check("full level", fifo_level, 4);
    wait_bits(44, 1000, "full bit count");
    idle(150);
    check("full no 5th frame", bits_q.size(), 44);
    take_frame(got);
    check("full frame0", got, {1'b1, 1'b0, 8'h01, 1'b0});
    take_frame(got);
    check("full frame1", got, {1'b1, 1'b0, 8'h02, 1'b0});
    take_frame(got);
    check("full frame2", got, {1'b1, 1'b1, 8'h03, 1'b0});
    take_frame(got);
    check("full frame3", got, {1'b1, 1'b0, 8'h04, 1'b0});
    check("full level drained", fifo_level, 0);

    // Host inhibit during the high phase of bit 5.
    bits_q.delete();
    d0 = done_cnt;
    a0 = abort_cnt;
    push_byte(8'h12);
    wait_bits(5, 300, "inhibit bits before");
    begin
      int k = 0;
      while (ps2clk_w !== 1'b1 && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("inhibit saw clock high", ps2clk_w, 1);
    end
    host_clk_low = 1'b1;
    idle(20);
    check("inhibit abort pulse", abort_cnt - a0, 1);
    check("inhibit data released", ps2data_w, 1);
    check("inhibit busy", busy, 0);
    check("inhibit level kept", fifo_level, 1);
    check("inhibit no done", done_cnt - d0, 0);
    host_clk_low = 1'b0;
    bits_q.delete();
    wait_bits(11, 300, "resend bit count");
    take_frame(got);
    check("resend frame", got, {1'b1, 1'b1, 8'h12, 1'b0});
    idle(CLK_HALF + 3);
    check("resend done", done_cnt - d0, 1);
    check("resend level", fifo_level, 0);
    idle(GAP_CYCLES + 4);

    // Reset in the low phase of bit 3.
    bits_q.delete();
    d0 = done_cnt;
    push_byte(8'h55);
    wait_bits(4, 300, "rst bits before");
    @(negedge clk);
    check("rst pre clock low", ps2clk_w, 0);
    rst = 1'b1;
    #1;
    check("rst ps2clk released", ps2clk_w, 1);
    check("rst ps2data released", ps2data_w, 1);
    check("rst level", fifo_level, 0);
    check("rst tx_ready", tx_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    idle(200);
    check("rst no done", done_cnt - d0, 0);
    check("rst no more bits", bits_q.size(), 4);

    // Host holds data low while a byte waits.
    bits_q.delete();
    host_data_low = 1'b1;
    push_byte(8'h6B);
    idle(100);
    check("hold busy", busy, 0);
    check("hold no bits", bits_q.size(), 0);
    check("hold level", fifo_level, 1);
    host_data_low = 1'b0;
    wait_bits(11, 300, "hold bit count");
    take_frame(got);
    check("hold frame", got, {1'b1, 1'b0, 8'h6B, 1'b0});
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
